// File: rtl/llc_set_walker_if.sv
// llc_set_walker_if: flush-request and set-offer handshake bundle between the walker and the LLC pipeline
interface llc_set_walker_if #(parameter int SET_BITS = 9);
  logic                flush_req_valid;
  logic                flush_req_ready;
  logic                set_out_valid;
  logic                set_out_ready;
  logic [SET_BITS-1:0] set_out;
  logic                set_out_is_rst;
  logic                set_out_last;
  logic                set_ack;
  modport master (
    input  flush_req_valid, set_out_ready, set_ack,
    output flush_req_ready, set_out_valid, set_out, set_out_is_rst, set_out_last
  );
  modport slave (
    output flush_req_valid, set_out_ready, set_ack,
    input  flush_req_ready, set_out_valid, set_out, set_out_is_rst, set_out_last
  );
endinterface

// File: rtl/llc_set_walker.sv
// llc_set_walker: invalidate/flush walk over all LLC sets with stall pulses; LLC_WALK_STAT_EN adds o_walk_cycles
module llc_set_walker #(
  parameter int SETS     = 512,
  parameter int SET_BITS = $clog2(SETS),
  parameter int MAX_OUT  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_rst_state,
  llc_set_walker_if.master bus,
  output logic o_clr_rst_flush_stalled_set,
  output logic o_incr_rst_flush_stalled_set,
  output logic o_set_flush_stall,
  output logic o_clr_flush_stall,
  output logic o_clr_rst_stall,
  output logic o_busy,
  output logic o_err_ack
`ifdef LLC_WALK_STAT_EN
  ,
  output logic [23:0] o_walk_cycles
`endif
);
  typedef enum logic [1:0] {IDLE, RST_WALK, FLUSH_WALK, DRAIN} state_t;
  state_t r_state, w_state_nxt;
  logic [SET_BITS-1:0] r_set_cnt;
  logic [3:0] r_out, w_out_nxt;
  logic r_rst_walk, r_clr_rsfs, r_set_fs, r_clr_fs, r_clr_rs, r_err;
  logic w_clr, w_walk, w_hs, w_accept, w_done;
  assign w_clr    = !rst || i_rst_state;
  assign w_walk   = r_state == RST_WALK || r_state == FLUSH_WALK;
  assign w_hs     = bus.set_out_valid && bus.set_out_ready;
  assign w_accept = bus.flush_req_ready && bus.flush_req_valid;
  assign w_out_nxt = (w_hs && !bus.set_ack) ? r_out + 4'd1 :
                     (!w_hs && bus.set_ack && r_out != 4'd0) ? r_out - 4'd1 : r_out;
  assign w_done   = r_state == DRAIN && w_out_nxt == 4'd0;
  assign bus.flush_req_ready = r_state == IDLE;
  assign bus.set_out_valid   = w_walk && r_out < 4'(MAX_OUT);
  assign bus.set_out         = r_set_cnt;
  assign bus.set_out_is_rst  = r_rst_walk;
  assign bus.set_out_last    = r_set_cnt == SET_BITS'(SETS - 1);
  assign o_incr_rst_flush_stalled_set = w_hs;
  assign o_clr_rst_flush_stalled_set  = r_clr_rsfs;
  assign o_set_flush_stall            = r_set_fs;
  assign o_clr_flush_stall            = r_clr_fs;
  assign o_clr_rst_stall              = r_clr_rs;
  assign o_busy                       = r_state != IDLE;
  assign o_err_ack                    = r_err;
  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) w_state_nxt = FLUSH_WALK;
    else if (w_hs && bus.set_out_last) w_state_nxt = DRAIN;
    else if (w_done) w_state_nxt = IDLE;
  end
  always_ff @(posedge clk) r_state <= w_clr ? RST_WALK : w_state_nxt;
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_set_cnt  <= '0;
      r_out      <= '0;
      r_rst_walk <= 1'b1;
      r_clr_rsfs <= 1'b1;
      r_set_fs   <= 1'b0;
      r_clr_fs   <= 1'b0;
      r_clr_rs   <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_set_cnt  <= w_accept ? '0 : r_set_cnt + SET_BITS'(w_hs);
      r_out      <= w_out_nxt;
      r_rst_walk <= w_accept ? 1'b0 : r_rst_walk;
      r_clr_rsfs <= w_accept;
      r_set_fs   <= w_accept;
      r_clr_fs   <= w_done && !r_rst_walk;
      r_clr_rs   <= w_done && r_rst_walk;
      r_err      <= r_err || (bus.set_ack && !w_hs && r_out == 4'd0);
    end
  end
`ifdef LLC_WALK_STAT_EN
  logic [23:0] r_walk_cycles;
  always_ff @(posedge clk) begin
    if (w_clr || w_accept) r_walk_cycles <= '0;
    else if (r_state != IDLE && r_walk_cycles != 24'hFFFFFF) r_walk_cycles <= r_walk_cycles + 24'd1;
  end
  assign o_walk_cycles = r_walk_cycles;
`endif
endmodule
